// File: rtl/brcomp_pipe.sv
// brcomp_pipe: pipelined branch comparator.
//
// This block compares two register-file operands and resolves the branch condition
// selected by br_op: EQ, NE, LT, GE, LTU or GEU. Valid bits travel alongside the
// data, so the block can sit inside a stall/flush controlled pipeline.
//
// Parameters
//   WIDTH     : operand width in bits (2..64)
//   STAGES    : latency in cycles. 1 means compare and register. 2 means register
//               the operands, then compare and register the result.
//   CNT_WIDTH : width of the statistics counters
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   valid_in       operands and op are valid this cycle
//   data_readRegA  operand A
//   data_readRegB  operand B
//   br_op          0=EQ 1=NE 2=LT 3=GE 4=LTU 5=GEU; 6 and 7 are illegal
//   stall          freeze every pipeline register
//   flush          clear every in-flight valid bit; flush wins over stall
//   valid_out      result valid
//   BrNEq          A != B
//   BrLT           A < B, signed
//   BrLTU          A < B, unsigned
//   taken          the condition selected by br_op is true
//   illegal_op     br_op was 6 or 7; taken is forced to 0
//   taken_count    taken branches retired (statistics build only, otherwise 0)
//   branch_count   valid branches retired (statistics build only, otherwise 0)
//
// Optional feature: define BRCOMP_STATS_EN to build the saturating retire counters.
module brcomp_pipe #(
  parameter int WIDTH     = 32,
  parameter int STAGES    = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [WIDTH-1:0]     data_readRegA,
  input  logic [WIDTH-1:0]     data_readRegB,
  input  logic [2:0]           br_op,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 valid_out,
  output logic                 BrNEq,
  output logic                 BrLT,
  output logic                 BrLTU,
  output logic                 taken,
  output logic                 illegal_op,
  output logic [CNT_WIDTH-1:0] taken_count,
  output logic [CNT_WIDTH-1:0] branch_count
);

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;

  // Signals that feed the compare stage.
  logic             cmp_v;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [2:0]       cmp_op;

  generate
    if (STAGES == 1) begin : g_one_stage
      assign cmp_v  = valid_in;
      assign cmp_a  = data_readRegA;
      assign cmp_b  = data_readRegB;
      assign cmp_op = br_op;
    end else begin : g_two_stage
      logic             s1_v_q;
      logic [WIDTH-1:0] s1_a_q;
      logic [WIDTH-1:0] s1_b_q;
      logic [2:0]       s1_op_q;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          s1_v_q  <= 1'b0;
          s1_a_q  <= '0;
          s1_b_q  <= '0;
          s1_op_q <= '0;
        end else if (flush) begin
          s1_v_q  <= 1'b0;
        end else if (!stall) begin
          s1_v_q  <= valid_in;
          s1_a_q  <= data_readRegA;
          s1_b_q  <= data_readRegB;
          s1_op_q <= br_op;
        end
      end

      assign cmp_v  = s1_v_q;
      assign cmp_a  = s1_a_q;
      assign cmp_b  = s1_b_q;
      assign cmp_op = s1_op_q;
    end
  endgenerate

  logic neq_d, lt_d, ltu_d, taken_d, illegal_d;

  always_comb begin
    neq_d     = |(cmp_a ^ cmp_b);
    // An unsigned magnitude compare is the borrow out of the WIDTH-bit A-B.
    ltu_d     = (cmp_a < cmp_b);
    // When the sign bits differ, A is the smaller value exactly when A is negative.
    // When they match, the unsigned order is also the signed order. This holds even
    // where A-B overflows.
    lt_d      = (cmp_a[WIDTH-1] != cmp_b[WIDTH-1]) ? cmp_a[WIDTH-1] : ltu_d;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (cmp_op)
      OP_EQ:   taken_d = !neq_d;
      OP_NE:   taken_d = neq_d;
      OP_LT:   taken_d = lt_d;
      OP_GE:   taken_d = !lt_d;
      OP_LTU:  taken_d = ltu_d;
      OP_GEU:  taken_d = !ltu_d;
      default: illegal_d = 1'b1;
    endcase
  end

  logic valid_q, neq_q, lt_q, ltu_q, taken_q, illegal_q;

  // Flags load only when a live entry arrives. A bubble or a flush therefore leaves
  // the last result on the output pins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      neq_q     <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (!stall) begin
        valid_q <= cmp_v;
      end
      if (!flush && !stall && cmp_v) begin
        neq_q     <= neq_d;
        lt_q      <= lt_d;
        ltu_q     <= ltu_d;
        taken_q   <= taken_d;
        illegal_q <= illegal_d;
      end
    end
  end

  assign valid_out  = valid_q;
  assign BrNEq      = neq_q;
  assign BrLT       = lt_q;
  assign BrLTU      = ltu_q;
  assign taken      = taken_q;
  assign illegal_op = illegal_q;

`ifdef BRCOMP_STATS_EN
  logic [CNT_WIDTH-1:0] branch_cnt_q;
  logic [CNT_WIDTH-1:0] taken_cnt_q;
  logic                 retire_en;

  // A result retires on the last cycle it is presented, which is the cycle that
  // has no stall. A stalled result is therefore counted once.
  assign retire_en = valid_q && !stall;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (retire_en) begin
      if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + CNT_WIDTH'(1);
      if (taken_q && (taken_cnt_q != '1)) taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign branch_count = branch_cnt_q;
  assign taken_count  = taken_cnt_q;
`else
  assign branch_count = '0;
  assign taken_count  = '0;
`endif

endmodule

// File: tb/tb_brcomp_pipe.sv
// Self-checking bench for brcomp_pipe (WIDTH=32, STAGES=2, CNT_WIDTH=4).
// Directed scenarios compare against hand-derived constants. The random scenario
// compares against a queue-based reference model.
module tb_brcomp_pipe;
  localparam int W  = 32;
  localparam int ST = 2;
  localparam int CW = 4;
  localparam int SATN = (1 << CW) - 1;
`ifdef BRCOMP_STATS_EN
  localparam logic [CW-1:0] SAT_EXP = '1;
`else
  localparam logic [CW-1:0] SAT_EXP = '0;
`endif

  logic clock = 1'b0, reset = 1'b0, valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic valid_out, BrNEq, BrLT, BrLTU, taken, illegal_op;
  logic [CW-1:0] taken_count, branch_count;
  int total = 0, bad = 0;

  brcomp_pipe #(.WIDTH(W), .STAGES(ST), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in),
    .data_readRegA(a), .data_readRegB(b), .br_op(op),
    .stall(stall), .flush(flush),
    .valid_out(valid_out), .BrNEq(BrNEq), .BrLT(BrLT), .BrLTU(BrLTU),
    .taken(taken), .illegal_op(illegal_op),
    .taken_count(taken_count), .branch_count(branch_count)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
  } ent_t;

  ent_t pipe_q[$];
  ent_t m_e;
  logic m_v = 1'b0;
  logic [4:0] m_flags = '0;   // {neq, lt, ltu, taken, illegal}
  int m_bc = 0, m_tc = 0;

  function automatic logic [4:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] o);
    logic neq, lt, ltu, tk;
    neq = (x != y);
    lt  = ($signed(x) < $signed(y));
    ltu = (x < y);
    case (o)
      3'd0: tk = !neq;
      3'd1: tk = neq;
      3'd2: tk = lt;
      3'd3: tk = !lt;
      3'd4: tk = ltu;
      3'd5: tk = !ltu;
      default: tk = 1'b0;
    endcase
    return {neq, lt, ltu, tk, (o > 3'd5)};
  endfunction

  function void model_clear(input logic all);
    pipe_q.delete();
    for (int i = 0; i < ST - 1; i++) pipe_q.push_back('0);
    m_v = 1'b0;
    if (all) begin
      m_flags = '0;
      m_bc = 0;
      m_tc = 0;
    end
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      model_clear(1'b1);
    end else begin
`ifdef BRCOMP_STATS_EN
      if (m_v && !stall) begin
        if (m_bc < SATN) m_bc++;
        if (m_flags[1] && m_tc < SATN) m_tc++;
      end
`endif
      if (flush) begin
        model_clear(1'b0);
      end else if (!stall) begin
        m_e.v = valid_in; m_e.a = a; m_e.b = b; m_e.op = op;
        pipe_q.push_front(m_e);
        m_e = pipe_q.pop_back();
        m_v = m_e.v;
        if (m_e.v) m_flags = ref_flags(m_e.a, m_e.b, m_e.op);
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
    total++; if ({BrNEq, BrLT, BrLTU, taken, illegal_op} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got=%b want=00000", {BrNEq, BrLT, BrLTU, taken, illegal_op}); end
    reset = 1'b1;
    // Three back-to-back entries (3 < 5): neq=1, lt=1, ltu=1, LT taken=1.
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; a = 32'd3; b = 32'd5; op = 3'd2;
      @(negedge clock);
    end
    total++; if (valid_out !== 1'b1 || taken !== 1'b1) begin bad++;
      $display("FAIL midstream_pre got v=%b t=%b want v=1 t=1", valid_out, taken); end
    #2 reset = 1'b0;
    #1;
    total++; if ({valid_out, BrNEq, BrLT, BrLTU, taken, illegal_op} !== 6'b0) begin bad++;
      $display("FAIL async_reset got=%b want=000000", {valid_out, BrNEq, BrLT, BrLTU, taken, illegal_op}); end
    @(negedge clock);
    reset = 1'b1; valid_in = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b want=0", valid_out); end
    end
    valid_in = 1'b1;
    for (int k = 1; k <= ST + 1; k++) begin
      @(negedge clock);
      valid_in = 1'b0;
      total++; if (valid_out !== (k == ST)) begin bad++;
        $display("FAIL post_reset_latency cyc=%0d got=%b want=%b", k, valid_out, (k == ST)); end
    end
    $display("txn reset sequence done");
  endtask

  task automatic test_edges();
    logic [W-1:0] va [5] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1234_5678, 32'h0000_0001};
    logic [W-1:0] vb [5] = '{32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h1234_5678, 32'h0000_0002};
    logic [2:0]   vo [5] = '{3'd2, 3'd4, 3'd3, 3'd0, 3'd7};
    // expected {neq, lt, ltu, taken, illegal}
    logic [4:0]   ve [5] = '{5'b11010, 5'b11000, 5'b10110, 5'b00010, 5'b11101};
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; a = va[i]; b = vb[i]; op = vo[i];
      @(negedge clock);
      valid_in = 1'b0;
      repeat (ST - 1) @(negedge clock);
      $display("txn edge a=%h b=%h op=%0d -> v=%b flags=%b", va[i], vb[i], vo[i], valid_out,
               {BrNEq, BrLT, BrLTU, taken, illegal_op});
      total++; if (valid_out !== 1'b1 || {BrNEq, BrLT, BrLTU, taken, illegal_op} !== ve[i]) begin bad++;
        $display("FAIL edge_%0d got v=%b f=%b want v=1 f=%b", i, valid_out,
                 {BrNEq, BrLT, BrLTU, taken, illegal_op}, ve[i]); end
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va [3] = '{32'd7, 32'd7, 32'hFFFF_FFFF};
    logic [W-1:0] vb [3] = '{32'd7, 32'd7, 32'd0};
    logic [2:0]   vo [3] = '{3'd0, 3'd1, 3'd2};
    logic         vt [3] = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k <= ST + 3; k++) begin
      if (k > 0) begin
        total++; if (valid_out !== (k >= ST && k < ST + 3)) begin bad++;
          $display("FAIL b2b_valid cyc=%0d got=%b want=%b", k, valid_out, (k >= ST && k < ST + 3)); end
        if (k >= ST && k < ST + 3) begin
          $display("txn b2b idx=%0d taken=%b", k - ST, taken);
          total++; if (taken !== vt[k - ST]) begin bad++;
            $display("FAIL b2b_taken idx=%0d got=%b want=%b", k - ST, taken, vt[k - ST]); end
        end
      end
      if (k < 3) begin valid_in = 1'b1; a = va[k]; b = vb[k]; op = vo[k]; end
      else valid_in = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic test_stall_flush();
    // Entry X is EQ(1,1) (taken 1). Entry Y is EQ(1,2) (taken 0).
    valid_in = 1'b1; a = 32'd1; b = 32'd1; op = 3'd0;
    @(negedge clock);
    b = 32'd2;
    @(negedge clock);
    valid_in = 1'b0; stall = 1'b1;
    total++; if (valid_out !== 1'b1 || taken !== 1'b1) begin bad++;
      $display("FAIL stall_pre got v=%b t=%b want v=1 t=1", valid_out, taken); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total++; if (valid_out !== 1'b1 || taken !== 1'b1 || BrNEq !== 1'b0) begin bad++;
        $display("FAIL stall_hold cyc=%0d got v=%b t=%b n=%b want v=1 t=1 n=0", k, valid_out, taken, BrNEq); end
    end
    stall = 1'b0;
    @(negedge clock);
    total++; if (valid_out !== 1'b1 || taken !== 1'b0 || BrNEq !== 1'b1) begin bad++;
      $display("FAIL stall_release got v=%b t=%b n=%b want v=1 t=0 n=1", valid_out, taken, BrNEq); end
    @(negedge clock);
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL stall_drain got=%b want=0", valid_out); end
    $display("txn stall sequence done");
    // Stall and flush together: both in-flight entries and the input are dropped.
    valid_in = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clock);
    b = 32'd2;
    @(negedge clock);
    stall = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd9;
    @(negedge clock);
    stall = 1'b0; flush = 1'b0; valid_in = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_now got=%b want=0", valid_out); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_after cyc=%0d got=%b want=0", k, valid_out); end
    end
    $display("txn flush sequence done");
  endtask

  task automatic test_random();
    logic [W-1:0] edge_v [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int c = 0; c < 400; c++) begin
      total++; if (valid_out !== m_v) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, valid_out, m_v); end
      if (m_v) begin
        total++; if ({BrNEq, BrLT, BrLTU, taken, illegal_op} !== m_flags) begin bad++;
          $display("FAIL rand_flags cyc=%0d got=%b want=%b", c, {BrNEq, BrLT, BrLTU, taken, illegal_op}, m_flags); end
        $display("txn rand cyc=%0d flags=%b", c, m_flags);
      end
      total++; if (branch_count !== CW'(m_bc) || taken_count !== CW'(m_tc)) begin bad++;
        $display("FAIL rand_counts cyc=%0d got b=%0d t=%0d want b=%0d t=%0d", c, branch_count, taken_count, m_bc, m_tc); end
      valid_in = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = a; end
        2: begin a = edge_v[$urandom_range(0, 4)]; b = edge_v[$urandom_range(0, 4)]; end
        default: begin a = $urandom; b = a ^ (32'd1 << $urandom_range(0, 31)); end
      endcase
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clock);
    end
    valid_in = 1'b0; stall = 1'b0; flush = 1'b0;
    repeat (ST + 1) @(negedge clock);
  endtask

  task automatic test_stats();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      valid_in = 1'b1; a = 32'(i); b = 32'(i); op = 3'd0;
      @(negedge clock);
    end
    valid_in = 1'b0;
    repeat (ST + 1) @(negedge clock);
    $display("txn stats after 20 taken: taken_count=%0d branch_count=%0d", taken_count, branch_count);
    total++; if (taken_count !== SAT_EXP) begin bad++; $display("FAIL stats_taken_sat got=%0d want=%0d", taken_count, SAT_EXP); end
    total++; if (branch_count !== SAT_EXP) begin bad++; $display("FAIL stats_branch_sat got=%0d want=%0d", branch_count, SAT_EXP); end
    valid_in = 1'b1; a = 32'd1; b = 32'd2; op = 3'd7;
    @(negedge clock);
    valid_in = 1'b0;
    repeat (ST - 1) @(negedge clock);
    total++; if (valid_out !== 1'b1 || illegal_op !== 1'b1 || taken !== 1'b0 || BrNEq !== 1'b1) begin bad++;
      $display("FAIL stats_illegal got v=%b i=%b t=%b n=%b want v=1 i=1 t=0 n=1", valid_out, illegal_op, taken, BrNEq); end
    repeat (2) @(negedge clock);
    total++; if (taken_count !== SAT_EXP) begin bad++; $display("FAIL stats_taken_after_illegal got=%0d want=%0d", taken_count, SAT_EXP); end
  endtask

  initial begin
    test_reset();
    test_edges();
    test_back_to_back();
    test_stall_flush();
    test_random();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
